// File: rtl/mapache64.sv
// Shared object-memory types for the mapache64 GPU.
package mapache64;
    localparam int NUM_OBJECTS  = 64;
    localparam int PATTERN_BITS = 5;

    typedef struct packed {
        logic [7:0]              x;
        logic [7:0]              y;
        logic [PATTERN_BITS-1:0] pattern_index;
        logic [3:0]              color;
        logic                    hflip;
        logic                    vflip;
    } obm_object_t;

    // An 8-row object covers the line when line_y is in [obj_y, obj_y+7]; 9-bit math keeps y=250.. from wrapping.
    function automatic logic covers_line(input logic [7:0] line_y, input logic [7:0] obj_y);
        logic [8:0] ly;
        logic [8:0] oy;
        ly = {1'b0, line_y};
        oy = {1'b0, obj_y};
        return (ly >= oy) && (ly <= oy + 9'd7);
    endfunction
endpackage

// File: rtl/object_scanline_sequencer_if.sv
// OBM, pattern-memory and scanline-buffer signals seen by the sequencer (master) and the fabric (slave).
interface object_scanline_sequencer_if #(
    parameter int NUM_OBJECTS  = 64,
    parameter int PATTERN_BITS = 5
);
    import mapache64::*;

    localparam int IDX_W = $clog2(NUM_OBJECTS);

    logic [IDX_W-1:0]          obm_addr_o;
    obm_object_t               obm_object_i;
    logic [PATTERN_BITS+2:0]   pmf_addr_o;
    logic [15:0]               pmf_row_i;
    logic                      obs_ready_i;
    logic                      obs_clear_start_o;
    logic [7:0]                obs_new_y_o;
    logic                      obs_load_start_o;
    obm_object_t               obs_load_object_o;
    logic [2:0]                obs_load_intx_i;
    logic [1:0]                obs_load_lightness_o;

    modport master (
        output obm_addr_o,
        input  obm_object_i,
        output pmf_addr_o,
        input  pmf_row_i,
        input  obs_ready_i,
        output obs_clear_start_o,
        output obs_new_y_o,
        output obs_load_start_o,
        output obs_load_object_o,
        input  obs_load_intx_i,
        output obs_load_lightness_o
    );

    modport slave (
        input  obm_addr_o,
        output obm_object_i,
        input  pmf_addr_o,
        output pmf_row_i,
        output obs_ready_i,
        input  obs_clear_start_o,
        input  obs_new_y_o,
        input  obs_load_start_o,
        input  obs_load_object_o,
        output obs_load_intx_i,
        input  obs_load_lightness_o
    );
endinterface

// File: rtl/object_scanline_sequencer.sv
// Per line: clears the scanline buffer, walks OBM from the last object down to 0, and paints each
// object covering the line; strobes only fire while the buffer reports ready.
module object_scanline_sequencer #(
    parameter int NUM_OBJECTS  = 64,
    parameter int PATTERN_BITS = 5
) (
    input  logic                               gpu_clk,
    input  logic                               rst,
    input  logic                               line_start_i,
    input  logic [7:0]                         line_y_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               overrun_o,
    object_scanline_sequencer_if.master        bus
);
    import mapache64::*;

    localparam int IDX_W = $clog2(NUM_OBJECTS);
    localparam int PMF_W = PATTERN_BITS + 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJECTS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR_REQ,
        S_CLEAR_WAIT,
        S_OBJ_RD,
        S_OBJ_CHK,
        S_ROW_RD,
        S_ROW_LATCH,
        S_LOAD_REQ,
        S_LOAD_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       y_q, y_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    obm_object_t      obj_q, obj_d;
    logic [15:0]      row_q, row_d;
    logic             overrun_q, overrun_d;

    logic             clear_start;
    logic             load_start;
    logic [2:0]       row_sel;
    logic [2:0]       pix_sel;

    always_ff @(posedge gpu_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            y_q       <= '0;
            idx_q     <= '0;
            obj_q     <= '0;
            row_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            idx_q     <= idx_d;
            obj_q     <= obj_d;
            row_q     <= row_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        idx_d       = idx_q;
        obj_d       = obj_q;
        row_d       = row_q;
        overrun_d   = overrun_q;
        clear_start = 1'b0;
        load_start  = 1'b0;

        // A line request is only accepted from IDLE; the DONE cycle already counts as busy.
        if (line_start_i && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (line_start_i) begin
                    y_d     = line_y_i;
                    idx_d   = LAST_IDX;
                    state_d = S_CLEAR_REQ;
                end
            end
            S_CLEAR_REQ: begin
                if (bus.obs_ready_i) begin
                    clear_start = 1'b1;
                    state_d     = S_CLEAR_WAIT;
                end
            end
            S_CLEAR_WAIT: begin
                if (bus.obs_ready_i) begin
                    state_d = S_OBJ_RD;
                end
            end
            S_OBJ_RD: begin
                state_d = S_OBJ_CHK;
            end
            S_OBJ_CHK: begin
                obj_d   = bus.obm_object_i;
                state_d = covers_line(y_q, bus.obm_object_i.y) ? S_ROW_RD : S_NEXT;
            end
            S_ROW_RD: begin
                state_d = S_ROW_LATCH;
            end
            S_ROW_LATCH: begin
                row_d   = bus.pmf_row_i;
                state_d = S_LOAD_REQ;
            end
            S_LOAD_REQ: begin
                if (bus.obs_ready_i) begin
                    load_start = 1'b1;
                    state_d    = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                // Truncated objects near the right edge finish early; waiting on ready covers both cases.
                if (bus.obs_ready_i) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = S_OBJ_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign row_sel = 3'(y_q - obj_q.y) ^ {3{obj_q.vflip}};
    assign pix_sel = bus.obs_load_intx_i ^ {3{obj_q.hflip}};

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign overrun_o = overrun_q;

    assign bus.obm_addr_o           = idx_q;
    assign bus.pmf_addr_o           = PMF_W'({obj_q.pattern_index, row_sel});
    assign bus.obs_clear_start_o    = clear_start;
    assign bus.obs_new_y_o          = y_q;
    assign bus.obs_load_start_o     = load_start;
    assign bus.obs_load_object_o    = obj_q;
    // Pixel p lives in row bits [15-2p -: 2], i.e. a right shift by 2*(7-p) = 2*~p.
    assign bus.obs_load_lightness_o = 2'(row_q >> {~pix_sel, 1'b0});
endmodule

// File: tb/tb_object_scanline_sequencer.sv
// Scoreboard bench: OBM/pattern memories and a behavioural scanline buffer around the sequencer.
module tb_object_scanline_sequencer;
    import mapache64::*;

    typedef struct packed {
        obm_object_t obj;
        logic [7:0]  paddr;
    } exp_load_t;

    logic       gpu_clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_start = 1'b0;
    logic [7:0] line_y = 8'd0;
    logic       busy;
    logic       done;
    logic       overrun;

    always #5 gpu_clk = ~gpu_clk;

    object_scanline_sequencer_if bus ();

    object_scanline_sequencer dut (
        .gpu_clk      (gpu_clk),
        .rst          (rst),
        .line_start_i (line_start),
        .line_y_i     (line_y),
        .busy_o       (busy),
        .done_o       (done),
        .overrun_o    (overrun),
        .bus          (bus.master)
    );

    obm_object_t obm_mem [64];
    logic [15:0] pmf_mem [256];

    always @(posedge gpu_clk) begin
        bus.obm_object_i <= obm_mem[bus.obm_addr_o];
        bus.pmf_row_i    <= pmf_mem[bus.pmf_addr_o];
    end

    // Behavioural scanline buffer: busy 256 cycles per clear, min(8, 256-x) cycles per paint.
    logic       buf_rdy = 1'b1;
    int         buf_cnt = 0;
    int         buf_pos = 0;
    logic       buf_ld = 1'b0;
    logic [7:0] buf_x = 8'd0;
    logic [3:0] buf_col = 4'd0;
    logic [3:0] pix [256] = '{default: 4'hF};

    assign bus.obs_ready_i     = buf_rdy;
    assign bus.obs_load_intx_i = buf_pos[2:0];

    always @(posedge gpu_clk) begin
        if (bus.obs_clear_start_o) begin
            buf_rdy <= 1'b0;
            buf_cnt <= 256;
            buf_ld  <= 1'b0;
            for (int i = 0; i < 256; i++) pix[i] <= 4'd0;
        end else if (bus.obs_load_start_o) begin
            buf_rdy <= 1'b0;
            buf_cnt <= (bus.obs_load_object_o.x > 8'd248) ? 256 - int'(bus.obs_load_object_o.x) : 8;
            buf_pos <= 0;
            buf_ld  <= 1'b1;
            buf_x   <= bus.obs_load_object_o.x;
            buf_col <= bus.obs_load_object_o.color;
        end else if (buf_cnt > 0) begin
            if (buf_ld && bus.obs_load_lightness_o != 2'd0) pix[8'(int'(buf_x) + buf_pos)] <= buf_col;
            buf_cnt <= buf_cnt - 1;
            buf_pos <= buf_pos + 1;
            if (buf_cnt == 1) buf_rdy <= 1'b1;
        end
    end

    logic [7:0] exp_clr_q [$];
    exp_load_t  exp_ld_q  [$];
    logic [1:0] exp_lt_q  [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int clr_seen = 0;
    int ld_seen = 0;
    int done_seen = 0;
    int clr_cyc = 0;
    int done_cyc = 0;

    always @(posedge gpu_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe / painted pixel pops the next expected item.
    always @(negedge gpu_clk) begin
        if (bus.obs_clear_start_o) begin
            check("clr_ready", 64'(bus.obs_ready_i), 64'd1);
            check("clr_pending", 64'(exp_clr_q.size() > 0), 64'd1);
            if (exp_clr_q.size() > 0) check("clr_y", 64'(bus.obs_new_y_o), 64'(exp_clr_q.pop_front()));
            clr_seen++;
            clr_cyc = cyc;
        end
        if (bus.obs_load_start_o) begin
            check("ld_ready", 64'(bus.obs_ready_i), 64'd1);
            check("ld_pending", 64'(exp_ld_q.size() > 0), 64'd1);
            if (exp_ld_q.size() > 0)
                check("ld_obj_paddr", 64'({bus.obs_load_object_o, bus.pmf_addr_o}), 64'(exp_ld_q.pop_front()));
            ld_seen++;
        end
        if (buf_ld && buf_cnt > 0) begin
            check("lt_pending", 64'(exp_lt_q.size() > 0), 64'd1);
            if (exp_lt_q.size() > 0) check("lightness", 64'(bus.obs_load_lightness_o), 64'(exp_lt_q.pop_front()));
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    function automatic obm_object_t mk_obj(input logic [7:0] x, input logic [7:0] y, input logic [4:0] pat,
                                           input logic [3:0] col, input logic hf, input logic vf);
        obm_object_t o;
        o.x = x; o.y = y; o.pattern_index = pat; o.color = col; o.hflip = hf; o.vflip = vf;
        return o;
    endfunction

    task automatic push_lt(input logic [1:0] v [8], input int n);
        for (int i = 0; i < n; i++) exp_lt_q.push_back(v[i]);
    endtask

    // Called #1 after an edge; the pulse is sampled by the next edge.
    task automatic start_line(input logic [7:0] y);
        line_y = y;
        line_start = 1'b1;
        @(posedge gpu_clk);
        #1 line_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int span);
        int d0;
        d0 = done_seen;
        for (int i = 0; i < 3000; i++) begin
            @(posedge gpu_clk);
            if (done_seen != d0) break;
        end
        #1;
        check({name, "_done"}, 64'(done_seen - d0), 64'd1);
        check({name, "_span"}, 64'(done_cyc - clr_cyc), 64'(span));
    endtask

    task automatic wait_count(input string name, ref int cnt, input int base);
        for (int i = 0; i < 3000; i++) begin
            @(posedge gpu_clk);
            if (cnt != base) break;
        end
        check({name, "_seen"}, 64'(cnt - base), 64'd1);
    endtask

    logic [1:0] lt8 [8];
    logic [3:0] acc;
    obm_object_t o5;
    obm_object_t o0;
    obm_object_t o1;

    initial begin
        for (int i = 0; i < 64; i++) obm_mem[i] = mk_obj(8'd0, 8'd200, 5'd0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) pmf_mem[i] = 16'h5555;

        rst = 1'b1;
        repeat (3) @(posedge gpu_clk);
        #1;
        check("reset_outs", 64'({busy, done, overrun, bus.obs_clear_start_o, bus.obs_load_start_o,
                                 bus.obm_addr_o, bus.pmf_addr_o, bus.obs_new_y_o, bus.obs_load_object_o,
                                 bus.obs_load_lightness_o}), 64'd0);
        rst = 1'b0;
        @(posedge gpu_clk);
        #1;

        // All objects off-line: one clear, no paints.
        exp_clr_q.push_back(8'd10);
        start_line(8'd10);
        wait_done("empty", 450);
        acc = 4'd0;
        for (int i = 0; i < 256; i++) acc = acc | pix[i];
        check("empty_pixels", 64'(acc), 64'd0);
        check("empty_no_loads", 64'(ld_seen), 64'd0);

        // Object 5, row 2 of pattern 3.
        o5 = mk_obj(8'd20, 8'd8, 5'd3, 4'h6, 1'b0, 1'b0);
        obm_mem[5] = o5;
        pmf_mem[8'h1A] = 16'hE4E4;
        pmf_mem[8'h1D] = 16'hE4E4;
        exp_clr_q.push_back(8'd10);
        exp_ld_q.push_back('{obj: o5, paddr: 8'h1A});
        lt8 = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        push_lt(lt8, 8);
        start_line(8'd10);
        wait_done("plain", 462);
        check("plain_pix20", 64'(pix[20]), 64'h6);
        check("plain_pix23", 64'(pix[23]), 64'h0);

        // Same object flipped both ways: row 5, pixels mirrored.
        o5 = mk_obj(8'd20, 8'd8, 5'd3, 4'h6, 1'b1, 1'b1);
        obm_mem[5] = o5;
        exp_clr_q.push_back(8'd10);
        exp_ld_q.push_back('{obj: o5, paddr: 8'h1D});
        lt8 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        push_lt(lt8, 8);
        start_line(8'd10);
        wait_done("flip", 462);
        check("flip_pix23", 64'(pix[23]), 64'h6);

        // Two overlapping objects: 1 is painted first, 0 last and wins.
        obm_mem[5] = mk_obj(8'd0, 8'd200, 5'd0, 4'd0, 1'b0, 1'b0);
        o1 = mk_obj(8'd40, 8'd0, 5'd1, 4'h9, 1'b0, 1'b0);
        o0 = mk_obj(8'd40, 8'd0, 5'd2, 4'hA, 1'b0, 1'b0);
        obm_mem[1] = o1;
        obm_mem[0] = o0;
        pmf_mem[8'h0B] = 16'hC000;
        pmf_mem[8'h13] = 16'h4000;
        exp_clr_q.push_back(8'd3);
        exp_ld_q.push_back('{obj: o1, paddr: 8'h0B});
        exp_ld_q.push_back('{obj: o0, paddr: 8'h13});
        lt8 = '{2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        push_lt(lt8, 8);
        lt8 = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        push_lt(lt8, 8);
        start_line(8'd3);
        wait_done("prio", 474);
        check("prio_pix40", 64'(pix[40]), 64'hA);

        // Right-edge object: buffer paints 4 pixels and comes back early.
        obm_mem[1] = mk_obj(8'd0, 8'd200, 5'd0, 4'd0, 1'b0, 1'b0);
        o0 = mk_obj(8'd252, 8'd0, 5'd4, 4'h5, 1'b0, 1'b0);
        obm_mem[0] = o0;
        pmf_mem[8'h23] = 16'hFFFF;
        exp_clr_q.push_back(8'd3);
        exp_ld_q.push_back('{obj: o0, paddr: 8'h23});
        lt8 = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        push_lt(lt8, 4);
        start_line(8'd3);
        wait_done("trunc", 458);
        check("trunc_pix255", 64'(pix[255]), 64'h5);

        // Overrun mid-scan, then reset while the buffer is painting.
        o0 = mk_obj(8'd100, 8'd0, 5'd6, 4'h7, 1'b0, 1'b0);
        obm_mem[0] = o0;
        pmf_mem[8'h33] = 16'h0000;
        exp_clr_q.push_back(8'd3);
        exp_ld_q.push_back('{obj: o0, paddr: 8'h33});
        lt8 = '{default: 2'd0};
        push_lt(lt8, 8);
        start_line(8'd3);
        wait_count("ovr_clr", clr_seen, clr_seen - 0 - 0 + 0 == clr_seen ? clr_seen : 0);
        repeat (300) @(posedge gpu_clk);
        #1;
        start_line(8'd50);
        check("overrun_set", 64'({overrun, busy}), 64'b11);
        wait_count("ovr_ld", ld_seen, ld_seen);
        #1 rst = 1'b1;
        @(posedge gpu_clk);
        #1;
        check("midrst_outs", 64'({busy, done, overrun, bus.obs_clear_start_o, bus.obs_load_start_o,
                                  bus.obm_addr_o, bus.pmf_addr_o, bus.obs_new_y_o, bus.obs_load_object_o,
                                  bus.obs_load_lightness_o}), 64'd0);
        rst = 1'b0;
        exp_clr_q.push_back(8'd3);
        exp_ld_q.push_back('{obj: o0, paddr: 8'h33});
        push_lt(lt8, 8);
        start_line(8'd3);
        check("no_clr_while_busy", 64'({bus.obs_ready_i, bus.obs_clear_start_o, busy}), 64'b001);
        wait_done("after_rst", 462);
        check("overrun_cleared", 64'(overrun), 64'd0);

        repeat (12) @(posedge gpu_clk);
        #1;
        check("clr_q_empty", 64'(exp_clr_q.size()), 64'd0);
        check("ld_q_empty", 64'(exp_ld_q.size()), 64'd0);
        check("lt_q_empty", 64'(exp_lt_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
